fir_mac_sequencer: RTL
======================

// Module: fir_mac_sequencer
// PURPOSE
//  Time-multiplexed FIR controller. Sequences one shared multiplier across TAPS coefficient/history pairs
//  per input sample, with a programmable coefficient register file and valid/ready streaming on both sides.
//  Sits between the sample source (ADC/stream front end) and downstream consumers as the area-reduced,
//  reconfigurable replacement for fully parallel fixed-coefficient FIR stages.
// PARAMETERS
//  DATA_W   16  sample width, signed two's complement
//  COEFF_W  16  coefficient width, signed
//  TAPS     3   number of taps (>=2)
//  ACC_W    DATA_W+COEFF_W+$clog2(TAPS)  accumulator width, signed; never overflows
//  SHIFT    18  arithmetic right shift applied to accumulator before saturation
// PORTS
//  clk        in   1        rising-edge clock
//  reset      in   1        asynchronous, active-high reset
//  flush      in   1        sync: clear history, abort current sample
//  in_valid   in   1        sample_in valid
//  in_ready   out  1        sequencer can accept sample_in
//  sample_in  in   DATA_W   input sample
//  out_valid  out  1        sample_out valid
//  out_ready  in   1        downstream accepts sample_out
//  sample_out out  DATA_W   filtered sample, registered
//  cfg_we     in   1        coefficient write strobe
//  cfg_addr   in   clog2(TAPS) coefficient index
//  cfg_data   in   COEFF_W  coefficient value
//  cfg_err    out  1        1-cycle pulse: write rejected
//  busy       out  1        high in MAC or OUT state
// BEHAVIOUR
//  Reset: state=IDLE, history[*]=0, acc=0, sample_out=0, out_valid=0, cfg_err=0; coeff[] = defaults {1024,2048,1024}
//    (TAPS>3: remaining defaults 0). in_ready=1 once reset deasserts.
//  FSM IDLE -> MAC -> OUT -> IDLE.
//   IDLE: in_ready = !flush. Accept on in_valid&&in_ready: history shifts (hist[k]<=hist[k-1], hist[0]<=sample_in),
//     acc<=0, tap<=0, go MAC.
//   MAC: one tap per cycle, acc += hist[tap]*coeff[tap] (full-precision signed product); after tap TAPS-1
//     go OUT and register result.
//   OUT: out_valid=1, sample_out stable; on out_ready go IDLE. in_ready=0 outside IDLE.
//  Latency: accept edge at cycle 0 -> out_valid high at cycle TAPS+1. Max throughput with out_ready tied high:
//    one sample per TAPS+2 cycles.
//  Arithmetic: result = sat_DATA_W(acc >>> SHIFT); shift is floor (toward -inf), no rounding; saturate to
//    [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//  Coefficients: cfg_we in IDLE with cfg_addr<TAPS writes coeff[cfg_addr] at that edge.
//    cfg_we in MAC/OUT -> ignored, cfg_err pulses next cycle. cfg_addr>=TAPS -> ignored, cfg_err pulses.
//  Simultaneous events:
//   - cfg_we + sample accept in the same IDLE cycle: write lands first; the MAC uses the new coefficient.
//   - flush has priority over everything except reset: history[*]<=0, state<=IDLE, out_valid<=0,
//     sample_out holds last value, coeffs retained; a sample presented that cycle is not accepted (in_ready=0).
//   - Reset mid-MAC/OUT: immediate return to reset values, including default coefficients.
//  busy = (state!=IDLE).
// STRUCTURE
//  fir_pkg: state encodings (IDLE/MAC/OUT), default coefficient table, sat/width helper functions.
//  Sub-module fir_mac_unit: registered signed multiply-accumulate (clr, en, a, b -> acc), instantiated once.
//  Coefficient RF, history shift register and FSM live in fir_mac_sequencer.
// TESTING
//  1 Impulse, defaults: sample_in 16384 then 0,0,0 (out_ready=1) -> sample_out 64,128,64,0;
//    out_valid exactly TAPS+1 cycles after each accept.
//  2 Backpressure: out_ready=0 for 10 cycles in OUT -> out_valid held, sample_out stable, in_ready=0;
//    release -> IDLE next cycle.
//  3 Saturation (SHIFT=15 instance): coeffs all -32768, samples -32768 x3 -> third output 32767;
//    coeffs 32767 with samples -32768 x3 -> -32768.
//  4 Config: write coeff[1]=-2048 in IDLE, impulse 16384 -> 64,-128,64; cfg_we during MAC -> cfg_err pulse,
//    coeff unchanged; cfg_addr=3 -> cfg_err.
//  5 Flush mid-MAC: accept 16384, assert flush at cycle 2 -> no out_valid, history zero;
//    next sample 0 -> output 0.
//  6 Reset mid-OUT after coeff reprogram -> out_valid=0, sample_out=0, coefficients back to
//    1024/2048/1024 (impulse test re-passes).

Source files
------------

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared state encoding, default coefficients and width helpers for the FIR sequencer
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } fir_state_t;

    localparam int DEF_COEFF_0 = 1024;
    localparam int DEF_COEFF_1 = 2048;
    localparam int DEF_COEFF_2 = 1024;

    // Taps beyond the built-in table power up as zero.
    function automatic int default_coeff(input int k);
        case (k)
            0:       return DEF_COEFF_0;
            1:       return DEF_COEFF_1;
            2:       return DEF_COEFF_2;
            default: return 0;
        endcase
    endfunction

    function automatic int acc_width(input int data_w, input int coeff_w, input int taps);
        return data_w + coeff_w + $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// rtl/fir_mac_unit.sv - registered signed multiply-accumulate shared across all taps
module fir_mac_unit #(
    parameter int A_W   = 16,
    parameter int B_W   = 16,
    parameter int ACC_W = 34
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [ACC_W-1:0] sum
);

    logic signed [ACC_W-1:0]   acc;
    logic signed [A_W+B_W-1:0] prod;

    assign prod = a * b;
    // sum is the running total including the current product, so the caller can
    // capture the final result on the same edge the last tap is accumulated.
    assign sum  = acc + ACC_W'(prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - time-multiplexed FIR: coefficient file, history shift register and MAC sequencing FSM
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int  DATA_W  = 16,
    parameter int  COEFF_W = 16,
    parameter int  TAPS    = 3,
    parameter int  ACC_W   = acc_width(DATA_W, COEFF_W, TAPS),
    parameter int  SHIFT   = 18,
    localparam int AW      = $clog2(TAPS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  sample_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [DATA_W-1:0]  sample_out,
    input  logic                      cfg_we,
    input  logic [AW-1:0]             cfg_addr,
    input  logic signed [COEFF_W-1:0] cfg_data,
    output logic                      cfg_err,
    output logic                      busy
);

    localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    fir_state_t                state;
    logic [AW-1:0]             tap;
    logic signed [DATA_W-1:0]  hist  [TAPS];
    logic signed [COEFF_W-1:0] coeff [TAPS];
    logic signed [ACC_W-1:0]   mac_sum;
    logic                      accept;
    logic                      mac_en;
    logic                      cfg_in_range;
    logic                      cfg_write;

    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] s;
        s = v >>> SHIFT;
        if (s > SAT_MAX) begin
            return SAT_MAX[DATA_W-1:0];
        end else if (s < SAT_MIN) begin
            return SAT_MIN[DATA_W-1:0];
        end
        return s[DATA_W-1:0];
    endfunction

    assign in_ready     = (state == ST_IDLE) && !flush;
    assign accept       = in_ready && in_valid;
    assign busy         = (state != ST_IDLE);
    assign mac_en       = (state == ST_MAC) && !flush;
    assign cfg_in_range = ({1'b0, cfg_addr} < (AW+1)'(TAPS));
    assign cfg_write    = cfg_we && !flush && (state == ST_IDLE) && cfg_in_range;

    fir_mac_unit #(
        .A_W   (DATA_W),
        .B_W   (COEFF_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk (clk),
        .rst (reset),
        .clr (accept),
        .en  (mac_en),
        .a   (hist[tap]),
        .b   (coeff[tap]),
        .sum (mac_sum)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            tap        <= '0;
            sample_out <= '0;
            out_valid  <= 1'b0;
            cfg_err    <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                hist[k]  <= '0;
                coeff[k] <= COEFF_W'(default_coeff(k));
            end
        end else begin
            cfg_err <= cfg_we && !flush && !((state == ST_IDLE) && cfg_in_range);
            // Write lands before a same-cycle accept, so the MAC sees the new value.
            if (cfg_write) begin
                coeff[cfg_addr] <= cfg_data;
            end

            if (flush) begin
                state     <= ST_IDLE;
                out_valid <= 1'b0;
                for (int k = 0; k < TAPS; k++) begin
                    hist[k] <= '0;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (in_valid) begin
                            for (int k = TAPS - 1; k > 0; k--) begin
                                hist[k] <= hist[k-1];
                            end
                            hist[0] <= sample_in;
                            tap     <= '0;
                            state   <= ST_MAC;
                        end
                    end
                    ST_MAC: begin
                        if (tap == LAST_TAP) begin
                            sample_out <= saturate(mac_sum);
                            out_valid  <= 1'b1;
                            state      <= ST_OUT;
                        end else begin
                            tap <= tap + 1'b1;
                        end
                    end
                    ST_OUT: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    end
                    default: begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
